// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, canonical NOP and default reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO with flush; when empty the head output keeps showing
// the most recently popped entry (or RESET_DATA after reset).
module fetch_buffer #(
  parameter int                WIDTH      = 64,
  parameter int                DEPTH      = 2,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_pop_ok  = pop && (r_count != '0);
  assign w_push_ok = push && !flush && (r_count < FULL);

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= RESET_DATA;
    end else begin
      // A pop in the flush cycle still completes, so remember what decode saw.
      if (w_pop_ok) r_last <= r_mem[r_rd_ptr];
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
      end
    end
  end

  assign head_data = (r_count != '0) ? r_mem[r_rd_ptr] : r_last;
  assign count     = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC/FSM with a single outstanding memory request and
// credit-based issue into a small buffer feeding decode.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter int               BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [XLEN-1:0]  id_pc
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e     r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_run;
  logic [CW-1:0]    w_count;
  logic [31+XLEN:0] w_head;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_still_waiting;
  logic [XLEN-1:0]  w_redirect_target;

  // r_run keeps imem_req low during reset and until the first clock after release.
  assign imem_req          = r_run && (r_state == ST_REQ) && (w_count < CW'(BUF_DEPTH));
  assign imem_addr         = r_pc;
  assign w_accept          = imem_req && imem_ready;
  assign w_push            = (r_state == ST_WAIT) && imem_rvalid && !redirect_valid;
  assign w_pop             = id_valid && id_ready;
  assign w_still_waiting   = (r_state != ST_REQ) && !imem_rvalid;
  assign w_redirect_target = redirect_pc & ~(XLEN'(3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_REQ;
      r_pc    <= RESET_PC;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (redirect_valid) begin
        r_pc <= w_redirect_target;
        // Any request still in flight after this edge must have its response discarded.
        r_state <= (w_accept || w_still_waiting) ? ST_DROP : ST_REQ;
      end else begin
        case (r_state)
          ST_REQ:  if (w_accept) r_state <= ST_WAIT;
          ST_WAIT: if (imem_rvalid) begin
                     r_state <= ST_REQ;
                     r_pc    <= r_pc + XLEN'(4);
                   end
          ST_DROP: if (imem_rvalid) r_state <= ST_REQ;
          default: r_state <= ST_REQ;
        endcase
      end
    end
  end

  fetch_buffer #(
    .WIDTH      (32 + XLEN),
    .DEPTH      (BUF_DEPTH),
    .RESET_DATA ({INSTR_NOP, RESET_PC})
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({imem_rdata, r_pc}),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head_data (w_head),
    .count     (w_count)
  );

  assign id_valid           = (w_count != '0);
  assign {id_instr, id_pc}  = w_head;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model, decode-order model and directed scenarios.
module tb_fetch_stage;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:2], 2'b11};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory: accepts after cfg_ready_delay cycles of request, answers cfg_lat cycles later.
  int          cfg_ready_delay = 0;
  int          cfg_lat = 1;
  bit          mem_busy = 0;
  int          lat_cnt = 0;
  int          rdy_cnt = 0;
  logic [31:0] pend_addr = '0;

  initial begin
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (mem_busy) begin
        if (lat_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instr_of(pend_addr);
          mem_busy    = 0;
        end else lat_cnt--;
      end
      imem_ready = 1'b0;
      if (!mem_busy && imem_req) begin
        if (rdy_cnt >= cfg_ready_delay) begin
          imem_ready = 1'b1;
          mem_busy   = 1;
          lat_cnt    = cfg_lat - 1;
          pend_addr  = imem_addr;
          rdy_cnt    = 0;
        end else rdy_cnt++;
      end
    end
  end

  // Decode-side model: a sequential stream from the last redirect/reset target.
  logic [31:0] exp_pc = RST_PC;
  bit          exp_flush = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_addr = '0;
  bit          dut_out = 0;
  logic [31:0] acc_q[$];
  logic [31:0] pop_q[$];

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        check("rst_imem_req", imem_req, 0);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, NOP);
        check("rst_id_pc", id_pc, RST_PC);
        exp_pc = RST_PC; exp_flush = 0; prev_hold = 0; dut_out = 0;
      end else begin
        if (exp_flush) check("flush_id_valid", id_valid, 0);
        if (prev_hold) begin
          check("hold_req", imem_req, 1);
          check("hold_addr", imem_addr, prev_addr);
        end
        if (imem_req) begin
          check("addr_align", imem_addr[1:0], 0);
          check("single_outstanding", dut_out, 0);
        end
        if (id_valid && id_ready) begin
          check("id_pc", id_pc, exp_pc);
          check("id_instr", id_instr, instr_of(exp_pc));
          pop_q.push_back(id_pc);
          exp_pc += 32'd4;
        end
        if (imem_rvalid) dut_out = 0;
        if (imem_req && imem_ready) begin
          dut_out = 1;
          acc_q.push_back(imem_addr);
        end
        exp_flush = redirect_valid;
        if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
        prev_hold = imem_req && !imem_ready && !redirect_valid;
        prev_addr = imem_addr;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    acc_q.delete();
    pop_q.delete();
  endtask

  // Returns at negedge+2 of the cycle in which an accept will occur.
  task automatic wait_acc(input string name);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      #2;
      if (imem_req && imem_ready) ok = 1;
    end
    check({name, "_accept_seen"}, ok, 1);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    @(negedge clk);
    redirect_valid = 1'b0;
    clear_logs();
  endtask

  initial begin
    int n;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    cyc(3);

    // 1: release reset, 1-cycle memory, decode always ready
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(posedge clk);
      #1;
      if (id_valid) n = i;
    end
    check("t1_first_valid_cycles", n, 3);
    cyc(8);
    check("t1_acc_count", acc_q.size() >= 3, 1);
    check("t1_acc0", acc_q[0], 32'h0);
    check("t1_acc1", acc_q[1], 32'h4);
    check("t1_acc2", acc_q[2], 32'h8);
    check("t1_pop_count", pop_q.size() >= 3, 1);
    check("t1_pop0", pop_q[0], 32'h0);
    check("t1_pop1", pop_q[1], 32'h4);
    check("t1_pop2", pop_q[2], 32'h8);
    $display("t1 done: accepts=%0d pops=%0d", acc_q.size(), pop_q.size());

    // 2: decode stalled -> exactly DEPTH fetches, then drain in order
    id_ready = 1'b0;
    do_redirect(32'h200);
    cyc(12);
    check("t2_acc_count", acc_q.size(), 2);
    check("t2_acc0", acc_q[0], 32'h200);
    check("t2_acc1", acc_q[1], 32'h204);
    check("t2_req_low_full", imem_req, 0);
    check("t2_no_pops", pop_q.size(), 0);
    id_ready = 1'b1;
    cyc(10);
    check("t2_pop0", pop_q[0], 32'h200);
    check("t2_pop1", pop_q[1], 32'h204);
    check("t2_acc2", acc_q[2], 32'h208);
    $display("t2 done: accepts=%0d pops=%0d", acc_q.size(), pop_q.size());

    // 3: redirect while waiting on a response
    cfg_lat = 3;
    wait_acc("t3");
    do_redirect(32'h103);
    cyc(15);
    check("t3_acc0", acc_q[0], 32'h100);
    check("t3_pop0", pop_q[0], 32'h100);
    check("t3_pop_count", pop_q.size() >= 2, 1);
    $display("t3 done: accepts=%0d pops=%0d", acc_q.size(), pop_q.size());

    // 4a: redirect in the same cycle as accept
    cfg_lat = 2;
    wait_acc("t4a");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    clear_logs();
    cyc(12);
    check("t4a_acc0", acc_q[0], 32'h300);
    check("t4a_pop0", pop_q[0], 32'h300);
    $display("t4a done: accepts=%0d pops=%0d", acc_q.size(), pop_q.size());

    // 4b: redirect in the same cycle as the response
    cfg_lat = 1;
    wait_acc("t4b");
    @(negedge clk);
    #2;
    check("t4b_rvalid_now", imem_rvalid, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    @(negedge clk);
    redirect_valid = 1'b0;
    clear_logs();
    #4;
    check("t4b_valid_low", id_valid, 0);
    cyc(12);
    check("t4b_acc0", acc_q[0], 32'h400);
    check("t4b_pop0", pop_q[0], 32'h400);
    $display("t4b done: accepts=%0d pops=%0d", acc_q.size(), pop_q.size());

    // 5: slow memory, request held while ready low
    cfg_ready_delay = 3;
    cfg_lat = 4;
    do_redirect(32'h500);
    cyc(60);
    check("t5_acc0", acc_q[0], 32'h500);
    check("t5_pop_count", pop_q.size() >= 4, 1);
    check("t5_pop0", pop_q[0], 32'h500);
    check("t5_pop3", pop_q[3], 32'h50C);
    $display("t5 done: accepts=%0d pops=%0d", acc_q.size(), pop_q.size());

    // 6: reset during an outstanding request
    cfg_ready_delay = 0;
    cfg_lat = 4;
    wait_acc("t6");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_req", imem_req, 0);
    check("t6_async_valid", id_valid, 0);
    check("t6_async_instr", id_instr, NOP);
    check("t6_async_pc", id_pc, RST_PC);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    cyc(20);
    check("t6_acc0", acc_q[0], RST_PC);
    check("t6_pop0", pop_q[0], RST_PC);
    check("t6_pop1", pop_q[1], RST_PC + 32'd4);
    $display("t6 done: accepts=%0d pops=%0d", acc_q.size(), pop_q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
